// File: rtl/window_pattern_gen.sv
// Parametrised raster generator with a clipped sub-window DE and multi-channel test pattern.
// Optional macro WINDOW_BORDER_EN forces all-ones on the window's outer pixel ring.
module window_pattern_gen #(
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned HTOTAL   = 2200,
    parameter int unsigned HSYNC    = 44,
    parameter int unsigned HBP      = 148,
    parameter int unsigned HACTIVE  = 1920,
    parameter int unsigned VTOTAL   = 1125,
    parameter int unsigned VSYNC    = 5,
    parameter int unsigned VBP      = 36,
    parameter int unsigned VACTIVE  = 1080
) (
    input  logic                      pclk,
    input  logic                      prst_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [11:0]               top,
    input  logic [11:0]               left,
    input  logic [11:0]               width,
    input  logic [11:0]               height,
    output logic                      vs,
    output logic                      hs,
    output logic                      de_frame,
    output logic                      de,
    output logic [DSIZE*CHANNELS-1:0] data,
    output logic                      frame_start,
    output logic [15:0]               hactive,
    output logic [15:0]               vactive
);

    localparam int unsigned CW     = 16;
    localparam int unsigned DW     = DSIZE * CHANNELS;
    localparam int unsigned HSTART = HSYNC + HBP;
    localparam int unsigned VSTART = VSYNC + VBP;

    logic [CW-1:0] r_hcnt, r_vcnt;
    logic [7:0]    r_frame_cnt;
    logic [CW-1:0] r_left, r_top, r_wclip, r_hclip;
    logic [1:0]    r_mode;

    logic          r_vs, r_hs, r_de_frame, r_de, r_frame_start;
    logic [DW-1:0] r_data;
    logic [15:0]   r_hactive, r_vactive;

    logic          w_origin;
    logic [CW-1:0] w_wroom, w_hroom, w_wclip_new, w_hclip_new;
    logic [CW-1:0] w_x, w_y, w_wx, w_wy;
    logic          w_de_frame, w_de, w_border;
    logic [DSIZE-1:0] w_chan;
    logic [DW-1:0] w_data;

    assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);

    // Window clip from the live config; only consumed on the frame-origin cycle.
    always_comb begin
        w_wclip_new = '0;
        w_hclip_new = '0;
        w_wroom     = CW'(HACTIVE) - CW'(left);
        w_hroom     = CW'(VACTIVE) - CW'(top);
        if (!((CW'(left) >= CW'(HACTIVE)) || (CW'(top) >= CW'(VACTIVE)) ||
              (width == '0) || (height == '0))) begin
            w_wclip_new = (CW'(width) < w_wroom) ? CW'(width) : w_wroom;
            w_hclip_new = (CW'(height) < w_hroom) ? CW'(height) : w_hroom;
        end
    end

    // Raster decode; positions left of / above an origin wrap to large values and fail the range tests.
    always_comb begin
        w_x        = r_hcnt - CW'(HSTART);
        w_y        = r_vcnt - CW'(VSTART);
        w_wx       = w_x - r_left;
        w_wy       = w_y - r_top;
        w_de_frame = (w_x < CW'(HACTIVE)) && (w_y < CW'(VACTIVE));
        w_de       = w_de_frame && (w_wx < r_wclip) && (w_wy < r_hclip);
        w_border   = (w_wx == '0) || (w_wx == r_wclip - CW'(1)) ||
                     (w_wy == '0) || (w_wy == r_hclip - CW'(1));
    end

    always_comb begin
        w_data = '0;
        w_chan = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            case (r_mode)
                2'd0:    w_chan = DSIZE'(w_wx);
                2'd1:    w_chan = DSIZE'(w_wy);
                2'd2:    w_chan = {DSIZE{w_wx[4] ^ w_wy[4]}};
                default: w_chan = DSIZE'(w_wx + CW'(r_frame_cnt) + CW'(16 * c));
            endcase
`ifdef WINDOW_BORDER_EN
            if (w_border) begin
                w_chan = '1;
            end
`endif
            w_data[c*DSIZE +: DSIZE] = w_chan;
        end
    end

    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_frame_cnt   <= '0;
            r_left        <= '0;
            r_top         <= '0;
            r_wclip       <= '0;
            r_hclip       <= '0;
            r_mode        <= '0;
            r_vs          <= 1'b0;
            r_hs          <= 1'b0;
            r_de_frame    <= 1'b0;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_data        <= '0;
            r_hactive     <= '0;
            r_vactive     <= '0;
        end else if (!enable) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_vs          <= 1'b0;
            r_hs          <= 1'b0;
            r_de_frame    <= 1'b0;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_data        <= '0;
            r_hactive     <= '0;
            r_vactive     <= '0;
        end else begin
            if (r_hcnt == CW'(HTOTAL - 1)) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == CW'(VTOTAL - 1)) ? '0 : r_vcnt + CW'(1);
            end else begin
                r_hcnt <= r_hcnt + CW'(1);
            end
            if (w_origin) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_left      <= CW'(left);
                r_top       <= CW'(top);
                r_mode      <= mode;
                r_wclip     <= w_wclip_new;
                r_hclip     <= w_hclip_new;
            end
            r_vs          <= r_vcnt < CW'(VSYNC);
            r_hs          <= r_hcnt < CW'(HSYNC);
            r_de_frame    <= w_de_frame;
            r_de          <= w_de;
            r_frame_start <= w_origin;
            r_data        <= w_de ? w_data : '0;
            r_hactive     <= w_origin ? w_wclip_new : r_wclip;
            r_vactive     <= w_origin ? w_hclip_new : r_hclip;
        end
    end

    assign vs          = r_vs;
    assign hs          = r_hs;
    assign de_frame    = r_de_frame;
    assign de          = r_de;
    assign data        = r_data;
    assign frame_start = r_frame_start;
    assign hactive     = r_hactive;
    assign vactive     = r_vactive;

endmodule
